// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle ARM control unit
// (FSM state codes, ALU control, condition codes, datapath mux selects).
package mc_pkg;

    // FSM state codes
    typedef logic [3:0] state_t;
    localparam state_t FETCH    = 4'd0;
    localparam state_t DECODE   = 4'd1;
    localparam state_t MEMADR   = 4'd2;
    localparam state_t MEMREAD  = 4'd3;
    localparam state_t MEMWB    = 4'd4;
    localparam state_t MEMWRITE = 4'd5;
    localparam state_t EXECUTER = 4'd6;
    localparam state_t EXECUTEI = 4'd7;
    localparam state_t ALUWB    = 4'd8;
    localparam state_t BRANCH   = 4'd9;
    localparam state_t LINK     = 4'd10;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_EOR   = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;

    // Data-processing cmd field values
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Instruction op field
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // ResultSrc and ALUSrcB encodings
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCB_RD2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;

endpackage

// File: rtl/mc_if.sv
// mc_if: controller <-> datapath signal bundle. master = control unit,
// slave = datapath side.
interface mc_if #(
    parameter int ALUCTRL_W = 3
);
    logic [19:0]          Instr;
    logic [3:0]           ALUFlags;
    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 MemWrite;
    logic                 IRWrite;
    logic [1:0]           ResultSrc;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic [1:0]           ImmSrc;
    logic [1:0]           RegSrc;
    logic                 RegWrite;
    logic [3:0]           Flags;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegSrc, RegWrite, Flags
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegSrc, RegWrite, Flags
    );
endinterface

// File: rtl/mc_condlogic.sv
// mc_condlogic: architectural NZCV flags, condition evaluation and the
// registered condition result (CondExR) that gates all later writes.
module mc_condlogic
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       cond_latch,
    input  logic       nz_write,
    input  logic       cv_write,
    output logic [3:0] flags,
    output logic       cond_ex
);

    logic [3:0] flags_reg;
    logic       cond_ex_reg;

    function automatic logic condcheck(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            COND_EQ: return z;
            COND_NE: return !z;
            COND_CS: return cy;
            COND_CC: return !cy;
            COND_MI: return n;
            COND_PL: return !n;
            COND_VS: return v;
            COND_VC: return !v;
            COND_HI: return cy && !z;
            COND_LS: return !cy || z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return !z && (n == v);
            COND_LE: return z || (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;   // 1111 never executes
        endcase
    endfunction

    // Condition sampled once at end of DECODE; flag writes honour it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_reg   <= 4'b0000;
            cond_ex_reg <= 1'b0;
        end else begin
            if (cond_latch)
                cond_ex_reg <= condcheck(cond, flags_reg);
            if (nz_write && cond_ex_reg)
                flags_reg[3:2] <= alu_flags[3:2];
            if (cv_write && cond_ex_reg)
                flags_reg[1:0] <= alu_flags[1:0];
        end
    end

    assign flags   = flags_reg;
    assign cond_ex = cond_ex_reg;

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit (FSM, ALU decoder, wait states).
// Optional macro MC_BL_EN: BL writes PC+4 to R14 in BRANCH (RegSrc=11 tells
// the datapath to use R14 as write address) and loads the target in LINK.
module mc_controller
    import mc_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int WAIT_CYC  = 0,
    parameter int CNT_W     = 4
) (
    input logic   clk,
    input logic   reset,
    mc_if.master  bus
);

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic [3:0]           cond, cmd, rd;
    logic [1:0]           op;
    logic                 i_bit, s_or_l, is_bl, unused_rn;
    logic                 mem_state, last_cyc, cond_ex;
    logic [2:0]           alu_dec;
    logic                 alu_valid, is_cmp, has_cv;
    logic                 pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
    logic                 nz_write, cv_write, cond_latch;
    logic [1:0]           result_src, alu_src_b, reg_src;
    logic [ALUCTRL_W-1:0] alu_control;
    logic [3:0]           flags;

    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign i_bit     = bus.Instr[13];
    assign cmd       = bus.Instr[12:9];
    assign s_or_l    = bus.Instr[8];     // S for data-processing, L for memory
    assign rd        = bus.Instr[3:0];
    assign unused_rn = ^bus.Instr[7:4];

`ifdef MC_BL_EN
    assign is_bl = bus.Instr[12];        // funct[4]; only consulted in BRANCH
`else
    assign is_bl = 1'b0;
`endif

    assign mem_state = (state_reg == FETCH) || (state_reg == MEMREAD) || (state_reg == MEMWRITE);
    assign last_cyc  = (cnt_reg == CNT_W'(WAIT_CYC));

    // ALU decoder: cmd to ALUControl plus which flags the op may touch
    always_comb begin
        alu_dec   = ALU_ADD;
        alu_valid = 1'b1;
        is_cmp    = 1'b0;
        has_cv    = 1'b0;
        case (cmd)
            CMD_ADD: has_cv = 1'b1;
            CMD_SUB: begin alu_dec = ALU_SUB; has_cv = 1'b1; end
            CMD_AND: alu_dec = ALU_AND;
            CMD_ORR: alu_dec = ALU_ORR;
            CMD_EOR: alu_dec = ALU_EOR;
            CMD_MOV: alu_dec = ALU_PASSB;
            CMD_CMP: begin alu_dec = ALU_SUB; is_cmp = 1'b1; has_cv = 1'b1; end
            default: alu_valid = 1'b0;
        endcase
    end

    // State and wait counter; counter only runs inside memory-access states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= FETCH;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= (mem_state && !last_cyc) ? cnt_reg + CNT_W'(1) : '0;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:    if (last_cyc) state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_DP:   state_next = i_bit ? EXECUTEI : EXECUTER;
                    OP_MEM:  state_next = MEMADR;
                    OP_BR:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = s_or_l ? MEMREAD : MEMWRITE;
            MEMREAD:  if (last_cyc) state_next = MEMWB;
            MEMWRITE: if (last_cyc) state_next = FETCH;
            EXECUTER, EXECUTEI: state_next = is_cmp ? FETCH : ALUWB;
            BRANCH:   state_next = is_bl ? LINK : FETCH;
            default:  state_next = FETCH;
        endcase
    end

    // Per-state datapath controls; strobes fire only in the final wait cycle
    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RD2;
        alu_control = ALUCTRL_W'(ALU_ADD);
        reg_src     = {op == OP_MEM, op == OP_BR};
        nz_write    = 1'b0;
        cv_write    = 1'b0;
        cond_latch  = 1'b0;
        case (state_reg)
            FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = last_cyc;
                pc_write   = last_cyc;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                cond_latch = 1'b1;
            end
            MEMADR:   alu_src_b = SRCB_IMM;
            MEMREAD:  adr_src   = 1'b1;
            MEMWB: begin
                result_src = RES_DATA;
                if (rd == 4'hF) pc_write  = cond_ex;
                else            reg_write = cond_ex;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = last_cyc && cond_ex;
            end
            EXECUTER, EXECUTEI: begin
                alu_src_b   = (state_reg == EXECUTEI) ? SRCB_IMM : SRCB_RD2;
                alu_control = ALUCTRL_W'(alu_dec);
                nz_write    = alu_valid && (s_or_l || is_cmp);
                cv_write    = has_cv && (s_or_l || is_cmp);
            end
            ALUWB: begin
                result_src = RES_ALUOUT;
                if (rd == 4'hF) pc_write  = cond_ex && alu_valid;
                else            reg_write = cond_ex && alu_valid;
            end
            BRANCH: begin
                result_src = RES_ALURESULT;
                if (is_bl) begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    reg_src   = 2'b11;
                    reg_write = cond_ex;
                end else begin
                    alu_src_b = SRCB_IMM;
                    pc_write  = cond_ex;
                end
            end
            LINK: begin
                result_src = RES_ALURESULT;
                alu_src_b  = SRCB_IMM;
                pc_write   = cond_ex;
            end
            default: ;
        endcase
    end

    mc_condlogic u_condlogic (
        .clk        (clk),
        .reset      (reset),
        .cond       (cond),
        .alu_flags  (bus.ALUFlags),
        .cond_latch (cond_latch),
        .nz_write   (nz_write),
        .cv_write   (cv_write),
        .flags      (flags),
        .cond_ex    (cond_ex)
    );

    // Write strobes are forced low for as long as reset is held
    assign bus.PCWrite    = pc_write  && !reset;
    assign bus.MemWrite   = mem_write && !reset;
    assign bus.IRWrite    = ir_write  && !reset;
    assign bus.RegWrite   = reg_write && !reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = reg_src;
    assign bus.Flags      = flags;

endmodule
